// File: rtl/program_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : program_dispatcher
// Purpose  : Routes board buttons/VGA/LEDs to one of N_PROG programs, with a
//            debounced select and a blanked, vsync-aligned switchover.
// Revision : 1.0 - initial release
// ============================================================================
module program_dispatcher #(
    parameter int N_PROG          = 4,
    parameter int SEL_W           = 2,
    parameter int DEFAULT_SEL     = 0,
    parameter int DEBOUNCE_CYC    = 1000000,
    parameter int BLANK_FRAMES    = 2,
    parameter int VS_TIMEOUT      = 2000000,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                 clk_100mhz,
    input  logic                 rst_n,
    input  logic [SEL_W-1:0]     sel_in,
    input  logic [4:0]           btn_in,
    output logic [N_PROG*5-1:0]  prog_btn_out,
    input  logic [N_PROG*12-1:0] prog_rgb_in,
    input  logic [N_PROG-1:0]    prog_hs_in,
    input  logic [N_PROG-1:0]    prog_vs_in,
    input  logic [N_PROG*16-1:0] prog_led_in,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic [15:0]          led,
    output logic [SEL_W-1:0]     active_sel,
    output logic                 switching,
    output logic                 sel_err
);

    localparam int c_N_SLOT = 2**SEL_W;
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_TO_W   = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
    localparam int c_FR_W   = $clog2(BLANK_FRAMES + 2);

    localparam logic [c_DB_W-1:0] c_DB_MAX   = c_DB_W'(DEBOUNCE_CYC);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(VS_TIMEOUT - 1);
    localparam logic [c_FR_W-1:0] c_FR_LAST  = c_FR_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
    localparam logic [SEL_W-1:0]  c_SEL_DEF  = SEL_W'(DEFAULT_SEL);
    localparam logic              c_SYNC_INACT = (SYNC_ACTIVE_LOW != 0);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_BLANK = 2'd2;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [SEL_W-1:0]  r_sel_meta, r_sel_sync, r_sel_last, r_sel_stable;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_sel_err;
    logic              w_sel_valid;
    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_active, r_pending, w_watch;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_FR_W-1:0] r_fr_cnt;
    logic              r_vs_prev, w_vs_edge;
    logic [11:0]       r_rgb;
    logic              r_hs, r_vs;
    logic [15:0]       r_led;
    logic [N_PROG*5-1:0] r_btn;

    logic [11:0] w_rgb [c_N_SLOT];
    logic        w_hs  [c_N_SLOT];
    logic        w_vs  [c_N_SLOT];
    logic [15:0] w_led [c_N_SLOT];

    // Async assert, synchronous release of the internal reset.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Unused select codes map to an idle slot with inactive syncs.
    for (genvar k = 0; k < c_N_SLOT; k++) begin : g_slot
        if (k < N_PROG) begin : g_used
            assign w_rgb[k] = prog_rgb_in[12*k +: 12];
            assign w_hs[k]  = prog_hs_in[k];
            assign w_vs[k]  = prog_vs_in[k];
            assign w_led[k] = prog_led_in[16*k +: 16];
        end else begin : g_pad
            assign w_rgb[k] = '0;
            assign w_hs[k]  = c_SYNC_INACT;
            assign w_vs[k]  = c_SYNC_INACT;
            assign w_led[k] = '0;
        end
    end

    assign w_sel_valid = (int'(r_sel_stable) < N_PROG);

    always_ff @(posedge clk_100mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sel_meta   <= c_SEL_DEF;
            r_sel_sync   <= c_SEL_DEF;
            r_sel_last   <= c_SEL_DEF;
            r_sel_stable <= c_SEL_DEF;
            r_db_cnt     <= '0;
            r_sel_err    <= 1'b0;
        end else begin
            r_sel_meta <= sel_in;
            r_sel_sync <= r_sel_meta;
            r_sel_last <= r_sel_sync;
            if (r_sel_sync != r_sel_last)  r_db_cnt <= '0;
            else if (r_db_cnt != c_DB_MAX) r_db_cnt <= r_db_cnt + 1'b1;
            if (r_db_cnt == c_DB_MAX) r_sel_stable <= r_sel_last;
            r_sel_err <= !w_sel_valid;
        end
    end

    // While waiting, the incoming program's vsync is the one that matters.
    assign w_watch   = (r_state == c_ST_WAIT) ? r_pending : r_active;
    assign w_vs_edge = (w_vs[w_watch] != c_SYNC_INACT) && (r_vs_prev == c_SYNC_INACT);

    always_ff @(posedge clk_100mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= c_ST_RUN;
            r_active  <= c_SEL_DEF;
            r_pending <= c_SEL_DEF;
            r_to_cnt  <= '0;
            r_fr_cnt  <= '0;
            r_vs_prev <= ~c_SYNC_INACT;
        end else begin
            r_vs_prev <= w_vs[w_watch];
            case (r_state)
                c_ST_RUN: begin
                    if (w_sel_valid && (r_sel_stable != r_active)) begin
                        r_pending <= r_sel_stable;
                        r_to_cnt  <= '0;
                        r_vs_prev <= ~c_SYNC_INACT;
                        r_state   <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (r_sel_stable == r_active) begin
                        r_state <= c_ST_RUN;
                    end else if (w_sel_valid && (r_sel_stable != r_pending)) begin
                        r_pending <= r_sel_stable;
                        r_to_cnt  <= '0;
                        r_vs_prev <= ~c_SYNC_INACT;
                    end else if (w_vs_edge || (r_to_cnt == c_TO_LAST)) begin
                        r_active  <= r_pending;
                        r_fr_cnt  <= '0;
                        r_vs_prev <= ~c_SYNC_INACT;
                        r_state   <= c_ST_BLANK;
                    end
                end
                c_ST_BLANK: begin
                    if (BLANK_FRAMES == 0) begin
                        r_state <= c_ST_RUN;
                    end else if (w_vs_edge) begin
                        if (r_fr_cnt == c_FR_LAST) r_state  <= c_ST_RUN;
                        else                       r_fr_cnt <= r_fr_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rgb <= '0;
            r_hs  <= c_SYNC_INACT;
            r_vs  <= c_SYNC_INACT;
            r_led <= '0;
            r_btn <= '0;
        end else begin
            r_rgb <= (r_state == c_ST_RUN) ? w_rgb[r_active] : 12'h000;
            r_hs  <= w_hs[r_active];
            r_vs  <= w_vs[r_active];
            r_led <= w_led[r_active];
            for (int k = 0; k < N_PROG; k++) begin
                r_btn[5*k +: 5] <= ((r_state != c_ST_WAIT) && (r_active == SEL_W'(k))) ? btn_in : 5'b00000;
            end
        end
    end

    assign {vga_r, vga_g, vga_b} = r_rgb;
    assign vga_hs       = r_hs;
    assign vga_vs       = r_vs;
    assign led          = r_led;
    assign prog_btn_out = r_btn;
    assign active_sel   = r_active;
    assign switching    = (r_state != c_ST_RUN);
    assign sel_err      = r_sel_err;

endmodule
`default_nettype wire

// File: doc/program_dispatcher.md
Name: program_dispatcher

Overview:
- Runtime-selectable dispatcher between N_PROG test programs (ray-marcher main, fixed-point tester, pattern generators, ...) sharing one board I/O set.
- Replaces compile-time commented-out instantiation: all programs are instantiated; this block routes buttons in and VGA/LED out for one program at a time.
- Switch-selected; switchover is debounced, blanked and aligned to the incoming program's vertical sync so the monitor never sees a torn frame.

Parameters:
- N_PROG, 4, number of program channels (2..16)
- SEL_W, 2, width of select input; must satisfy 2**SEL_W >= N_PROG
- DEFAULT_SEL, 0, program active after reset
- DEBOUNCE_CYC, 1000000, cycles the select must be stable before acceptance (10 ms at 100 MHz)
- BLANK_FRAMES, 2, full frames of black output after switchover
- VS_TIMEOUT, 2000000, max cycles to wait for a vsync edge before forcing the switch
- SYNC_ACTIVE_LOW, 1, polarity of hs/vs pulses

Ports:
- clk_100mhz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel_in  in  SEL_W  raw program select from switches (asynchronous)
- btn_in  in  5  raw {btnc,btnl,btnr,btnu,btnd}
- prog_btn_out  out  N_PROG*5  per-program button bus; slice k = btn_in only when k active, else 0
- prog_rgb_in  in  N_PROG*12  per-program {r,g,b} 4 bits each, slice k at [12k+:12]
- prog_hs_in  in  N_PROG  per-program hsync
- prog_vs_in  in  N_PROG  per-program vsync
- prog_led_in  in  N_PROG*16  per-program LED bus
- vga_r, vga_g, vga_b  out  4 each  muxed colour
- vga_hs, vga_vs  out  1 each  muxed sync
- led  out  16  muxed LEDs
- active_sel  out  SEL_W  currently routed program
- switching  out  1  high in WAIT_VS and BLANK
- sel_err  out  1  high while debounced select >= N_PROG

Behaviour:
- Reset (async assert, sync deassert via 2-FF): state RUN, active_sel=DEFAULT_SEL, vga rgb=0, hs/vs = inactive level (1 if SYNC_ACTIVE_LOW), led=0, switching=0, sel_err=0, debounce counter 0, prog_btn_out=0.
- sel_in passes 2-FF synchroniser; debounce counter resets on any change of synced value, increments otherwise, saturates at DEBOUNCE_CYC; on reaching it, value latched as sel_stable.
- sel_err = (sel_stable >= N_PROG), registered; out-of-range select never triggers a switch, active program unchanged.
- Datapath: all outputs registered, 1-cycle latency from prog_*_in of active_sel to vga/led outputs.
- RUN: route active program fully. If sel_stable valid and != active_sel -> latch pending_sel, go WAIT_VS, reset timeout counter.
- WAIT_VS: rgb forced 0; hs/vs/led still from old program. Watch pending program's vs for assertion edge (inactive->active). On edge or timeout counter == VS_TIMEOUT-1: active_sel<=pending_sel, frame counter=0, go BLANK.
- BLANK: rgb forced 0; hs/vs/led and buttons from new active_sel. Each vs assertion edge of active program increments frame counter; at BLANK_FRAMES -> RUN. BLANK_FRAMES=0 -> RUN next cycle.
- Select changes to a different valid value during WAIT_VS: pending_sel updated, timeout counter restarted. During BLANK: ignored until RUN, then re-evaluated. Select returns to active_sel during WAIT_VS: abort to RUN, no blanking continues.
- Buttons: prog_btn_out slice active_sel = btn_in (registered, 1 cycle); during WAIT_VS all slices 0.
- Reset mid-switch: immediate return to DEFAULT_SEL, RUN, pending discarded.
- vs edge detection uses 1-cycle-delayed copy of selected vs; edge detector history cleared on active_sel change.

Test Plan:
- Bench DEBOUNCE_CYC=4, BLANK_FRAMES=2, VS_TIMEOUT=100, N_PROG=3. Reset, sel_in=0 -> active_sel=0, vga_hs=vga_vs=1, rgb=0 during reset; after release prog0 rgb 0xABC appears on vga one cycle later.
- sel_in glitches 0->1->0 for 3 cycles -> no WAIT_VS, switching stays 0.
- sel_in=1 held; prog1 vs falls 20 cycles later -> switching rises after sync+debounce, active_sel=1 one cycle after edge, rgb=0 for two prog1 frames, then prog1 rgb 0x123 passes, switching=0.
- sel_in=2 with prog2 vs tied inactive -> switch forced exactly 100 cycles after entering WAIT_VS.
- sel_in=3 (>= N_PROG) -> sel_err=1, active_sel unchanged, outputs uninterrupted.
- Assert rst_n mid-BLANK -> outputs return to reset values asynchronously; after release active_sel=0, RUN; btn_in=5'b10000 appears only on prog_btn_out slice 0.
